// File: rtl/sfp_link_ctrl.sv
// SFP optical port bring-up and supervision: sequences laser disable, transceiver/PCS
// resets and lock qualification, with TX-fault recovery and bounded retries.
module sfp_link_ctrl #(
   parameter int unsigned TXD_HOLD_CYCLES    = 1000,
   parameter int unsigned GT_RST_CYCLES      = 64,
   parameter int unsigned STEP_TIMEOUT       = 1000000,
   parameter int unsigned LOCK_STABLE_CYCLES = 256,
   parameter int unsigned TXF_RECOVER_CYCLES = 10000,
   parameter int unsigned MAX_RETRY          = 8,
   parameter logic        RS_DEFAULT         = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       enable,
   input  logic       rate_sel,
   input  logic       sfp_sgd,
   input  logic       sfp_txf,
   input  logic       gt_reset_done,
   input  logic       pcs_block_lock,
   output logic       sfp_txd,
   output logic       sfp_rs,
   output logic       gt_reset,
   output logic       pcs_reset,
   output logic       link_up,
   output logic       fault,
   output logic [7:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_TX_DIS     = 3'd1,
      S_GT_RST     = 3'd2,
      S_WAIT_RDY   = 3'd3,
      S_WAIT_LOCK  = 3'd4,
      S_LINK_UP    = 3'd5,
      S_FAULT_HOLD = 3'd6,
      S_FAILED     = 3'd7
   } state_t;

   localparam logic [23:0] C_TXD    = 24'(TXD_HOLD_CYCLES - 1);
   localparam logic [23:0] C_GT     = 24'(GT_RST_CYCLES - 1);
   localparam logic [23:0] C_TO     = 24'(STEP_TIMEOUT - 1);
   localparam logic [23:0] C_STABLE = 24'(LOCK_STABLE_CYCLES);
   localparam logic [23:0] C_TXF    = 24'(TXF_RECOVER_CYCLES - 1);
   localparam logic [7:0]  C_MAXR   = 8'(MAX_RETRY);

   state_t      r_state;
   logic [23:0] r_cnt;
   logic [23:0] r_stable;
   logic [7:0]  r_retry;
   logic        r_txd, r_rs, r_gt_reset, r_pcs_reset, r_link_up, r_fault;

   logic [23:0] w_stable_nxt;
   logic        w_lock_ok;
   logic        w_active;
   logic        w_retry_req;
   logic [7:0]  w_retry_inc;

   // Output pattern {txd, gt_reset, pcs_reset, link_up, fault} held while in a state.
   function automatic logic [4:0] f_outs(input state_t s);
      case (s)
         S_IDLE, S_TX_DIS: f_outs = 5'b11100;
         S_GT_RST:         f_outs = 5'b01100;
         S_WAIT_RDY:       f_outs = 5'b00100;
         S_WAIT_LOCK:      f_outs = 5'b00000;
         S_LINK_UP:        f_outs = 5'b00010;
         default:          f_outs = 5'b11101;
      endcase
   endfunction

   function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_stable_nxt = pcs_block_lock ? r_stable + 24'd1 : 24'd0;
   assign w_lock_ok    = (w_stable_nxt == C_STABLE);
   assign w_active     = (r_state != S_IDLE) && (r_state <= S_LINK_UP);
   assign w_retry_inc  = f_sat_inc(r_retry);

   always_comb begin
      w_retry_req = 1'b0;
      case (r_state)
         S_WAIT_RDY:   w_retry_req = !(gt_reset_done && sfp_sgd) && (r_cnt == C_TO);
         S_WAIT_LOCK:  w_retry_req = !sfp_sgd || (!w_lock_ok && (r_cnt == C_TO));
         S_FAULT_HOLD: w_retry_req = !sfp_txf && (r_cnt == 24'd0);
         default:      w_retry_req = 1'b0;
      endcase
   end

   // Priority: reset, shutdown, TX fault, failed attempt, then per-state sequencing.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_IDLE);
         r_rs     <= RS_DEFAULT;
         r_retry  <= 8'd0;
         r_cnt    <= 24'd0;
         r_stable <= 24'd0;
      end else if (!enable) begin
         r_state  <= S_IDLE;
         {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_IDLE);
         r_retry  <= 8'd0;
         r_cnt    <= 24'd0;
         r_stable <= 24'd0;
      end else if (sfp_txf && w_active) begin
         r_state <= S_FAULT_HOLD;
         {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_FAULT_HOLD);
         r_cnt   <= C_TXF;
      end else if (w_retry_req) begin
         r_retry <= w_retry_inc;
         if (w_retry_inc == C_MAXR) begin
            r_state <= S_FAILED;
            {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_FAILED);
         end else begin
            r_state <= S_TX_DIS;
            {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_TX_DIS);
            r_cnt   <= C_TXD;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_TX_DIS;
               {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_TX_DIS);
               r_rs    <= rate_sel;
               r_cnt   <= C_TXD;
            end
            S_TX_DIS: begin
               if (r_cnt == 24'd0) begin
                  r_state <= S_GT_RST;
                  {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_GT_RST);
                  r_cnt   <= C_GT;
               end else begin
                  r_cnt <= r_cnt - 24'd1;
               end
            end
            S_GT_RST: begin
               if (r_cnt == 24'd0) begin
                  r_state <= S_WAIT_RDY;
                  {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_WAIT_RDY);
               end else begin
                  r_cnt <= r_cnt - 24'd1;
               end
            end
            S_WAIT_RDY: begin
               if (gt_reset_done && sfp_sgd) begin
                  r_state  <= S_WAIT_LOCK;
                  {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_WAIT_LOCK);
                  r_cnt    <= 24'd0;
                  r_stable <= 24'd0;
               end else begin
                  r_cnt <= r_cnt + 24'd1;
               end
            end
            S_WAIT_LOCK: begin
               if (w_lock_ok) begin
                  r_state <= S_LINK_UP;
                  {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_LINK_UP);
                  r_retry <= 8'd0;
               end else begin
                  r_cnt    <= r_cnt + 24'd1;
                  r_stable <= w_stable_nxt;
               end
            end
            S_LINK_UP: begin
               // A loss of lock or light restarts bring-up without counting as a failure.
               if (!pcs_block_lock || !sfp_sgd) begin
                  r_state <= S_TX_DIS;
                  {r_txd, r_gt_reset, r_pcs_reset, r_link_up, r_fault} <= f_outs(S_TX_DIS);
                  r_cnt   <= C_TXD;
               end
            end
            S_FAULT_HOLD: r_cnt <= sfp_txf ? C_TXF : r_cnt - 24'd1;
            S_FAILED: ;
         endcase
      end
   end

   assign sfp_txd   = r_txd;
   assign sfp_rs    = r_rs;
   assign gt_reset  = r_gt_reset;
   assign pcs_reset = r_pcs_reset;
   assign link_up   = r_link_up;
   assign fault     = r_fault;
   assign retry_cnt = r_retry;
   assign state     = r_state;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Bench for sfp_link_ctrl: directed bring-up scenarios plus randomized stimulus, all
// compared against a phase/elapsed-time reference model of the link controller.
module tb_sfp_link_ctrl;

   localparam int TXD_HOLD = 8;
   localparam int GT_RST   = 4;
   localparam int STEP_TO  = 100;
   localparam int LOCK_ST  = 16;
   localparam int TXF_REC  = 10;
   localparam int MAXR     = 3;

   logic       CLK = 1'b0;
   logic       RESET, enable, rate_sel, sfp_sgd, sfp_txf, gt_reset_done, pcs_block_lock;
   logic       sfp_txd, sfp_rs, gt_reset, pcs_reset, link_up, fault;
   logic [7:0] retry_cnt;
   logic [2:0] state;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 CLK = ~CLK;

   sfp_link_ctrl #(
      .TXD_HOLD_CYCLES(TXD_HOLD), .GT_RST_CYCLES(GT_RST), .STEP_TIMEOUT(STEP_TO),
      .LOCK_STABLE_CYCLES(LOCK_ST), .TXF_RECOVER_CYCLES(TXF_REC), .MAX_RETRY(MAXR),
      .RS_DEFAULT(1'b1)
   ) dut (
      .CLK(CLK), .RESET(RESET), .enable(enable), .rate_sel(rate_sel), .sfp_sgd(sfp_sgd),
      .sfp_txf(sfp_txf), .gt_reset_done(gt_reset_done), .pcs_block_lock(pcs_block_lock),
      .sfp_txd(sfp_txd), .sfp_rs(sfp_rs), .gt_reset(gt_reset), .pcs_reset(pcs_reset),
      .link_up(link_up), .fault(fault), .retry_cnt(retry_cnt), .state(state)
   );

   // Reference model: phase number plus elapsed-time / consecutive-event tallies.
   int   m_state = 0, m_time = 0, m_stable = 0, m_low = 0, m_retry = 0;
   logic m_rs = 1'b1;

   logic [16:0] w_dut, w_exp;
   assign w_dut = {state, sfp_txd, sfp_rs, gt_reset, pcs_reset, link_up, fault, retry_cnt};
   always_comb begin
      w_exp = {3'(m_state),
               1'(m_state == 0 || m_state == 1 || m_state >= 6),
               m_rs,
               1'(m_state <= 2 || m_state >= 6),
               1'(m_state <= 3 || m_state >= 6),
               1'(m_state == 5),
               1'(m_state >= 6),
               8'(m_retry)};
   end

   task automatic attempt_failed();
      if (m_retry < 255) m_retry++;
      if (m_retry == MAXR) m_state = 7;
      else begin m_state = 1; m_time = 0; end
   endtask

   task automatic model_step();
      if (RESET) begin
         m_state = 0; m_rs = 1'b1; m_retry = 0; m_time = 0; m_stable = 0; m_low = 0;
      end else if (!enable) begin
         m_state = 0; m_retry = 0;
      end else if (sfp_txf && m_state >= 1 && m_state <= 5) begin
         m_state = 6; m_low = 0;
      end else begin
         case (m_state)
            0: begin m_rs = rate_sel; m_state = 1; m_time = 0; end
            1: begin m_time++; if (m_time == TXD_HOLD) begin m_state = 2; m_time = 0; end end
            2: begin m_time++; if (m_time == GT_RST) begin m_state = 3; m_time = 0; end end
            3: begin
               if (gt_reset_done && sfp_sgd) begin m_state = 4; m_time = 0; m_stable = 0; end
               else begin m_time++; if (m_time == STEP_TO) attempt_failed(); end
            end
            4: begin
               m_stable = pcs_block_lock ? m_stable + 1 : 0;
               m_time++;
               if (!sfp_sgd) attempt_failed();
               else if (m_stable == LOCK_ST) begin m_state = 5; m_retry = 0; end
               else if (m_time == STEP_TO) attempt_failed();
            end
            5: if (!pcs_block_lock || !sfp_sgd) begin m_state = 1; m_time = 0; end
            6: begin
               m_low = sfp_txf ? 0 : m_low + 1;
               if (m_low == TXF_REC) attempt_failed();
            end
            default: ;
         endcase
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; enable = 1'b1; rate_sel = 1'b0;
      repeat (3) cyc();
      n_checks++;
      if (w_dut !== 17'b000_1_1_1_1_0_0_00000000) begin
         n_fails++; $display("FAIL reset_values: got %h, want %h", w_dut, 17'b000_1_1_1_1_0_0_00000000);
      end
      RESET = 1'b0; enable = 1'b0;
      cyc();
      n_checks++;
      if (w_dut !== w_exp) begin n_fails++; $display("FAIL reset_idle: got %h, want %h", w_dut, w_exp); end
   endtask

   task automatic test_clean_bringup();
      int t_txd, t_gt, t_lu;
      t_txd = 0; t_gt = 0; t_lu = 0;
      sfp_sgd = 1'b1; gt_reset_done = 1'b1; pcs_block_lock = 1'b1; sfp_txf = 1'b0;
      rate_sel = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         n_checks++;
         if (w_dut !== w_exp) begin n_fails++; $display("FAIL clean_model k=%0d: got %h, want %h", k, w_dut, w_exp); end
         if (t_txd == 0 && !sfp_txd) t_txd = k;
         if (t_gt == 0 && !gt_reset) t_gt = k;
         if (t_lu == 0 && link_up) t_lu = k;
      end
      n_checks++;
      if (t_txd != 1 + TXD_HOLD) begin n_fails++; $display("FAIL clean_txd_fall: got %0d, want %0d", t_txd, 1 + TXD_HOLD); end
      n_checks++;
      if (t_gt != 1 + TXD_HOLD + GT_RST) begin n_fails++; $display("FAIL clean_gt_fall: got %0d, want %0d", t_gt, 1 + TXD_HOLD + GT_RST); end
      n_checks++;
      if (t_lu != 2 + TXD_HOLD + GT_RST + LOCK_ST) begin
         n_fails++; $display("FAIL clean_link_up: got %0d, want %0d", t_lu, 2 + TXD_HOLD + GT_RST + LOCK_ST);
      end
      n_checks++;
      if (retry_cnt !== 8'd0 || sfp_rs !== 1'b1) begin
         n_fails++; $display("FAIL clean_retry_rs: got retry=%0d rs=%b, want 0 1", retry_cnt, sfp_rs);
      end
   endtask

   task automatic test_no_lock();
      int n;
      n = 0;
      enable = 1'b0; cyc();
      pcs_block_lock = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 600; k++) begin
         cyc();
         n_checks++;
         if (w_dut !== w_exp) begin n_fails++; $display("FAIL nolock_model k=%0d: got %h, want %h", k, w_dut, w_exp); end
         if (state == 3'd7) begin n = k; break; end
      end
      n_checks++;
      if (n != 1 + MAXR * (TXD_HOLD + GT_RST + 1 + STEP_TO)) begin
         n_fails++; $display("FAIL nolock_failed_time: got %0d, want %0d", n, 1 + MAXR * (TXD_HOLD + GT_RST + 1 + STEP_TO));
      end
      n_checks++;
      if ({fault, sfp_txd, retry_cnt} !== {1'b1, 1'b1, 8'd3}) begin
         n_fails++; $display("FAIL nolock_failed_outs: got fault=%b txd=%b retry=%0d, want 1 1 3", fault, sfp_txd, retry_cnt);
      end
      repeat (5) cyc();
      n_checks++;
      if (state !== 3'd7) begin n_fails++; $display("FAIL nolock_failed_hold: got %0d, want 7", state); end
      enable = 1'b0; cyc();
      n_checks++;
      if ({state, retry_cnt, fault} !== {3'd0, 8'd0, 1'b0}) begin
         n_fails++; $display("FAIL nolock_disable: got state=%0d retry=%0d fault=%b, want 0 0 0", state, retry_cnt, fault);
      end
   endtask

   task automatic test_lock_glitch();
      int n;
      n = 0;
      pcs_block_lock = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         cyc();
         if (state == 3'd4) begin n = k; break; end
      end
      n_checks++;
      if (n == 0) begin n_fails++; $display("FAIL glitch_reach_wait_lock: got state %0d, want 4", state); end
      repeat (10) cyc();
      pcs_block_lock = 1'b0; cyc();
      n_checks++;
      if ({state, link_up} !== {3'd4, 1'b0}) begin
         n_fails++; $display("FAIL glitch_drop: got state=%0d link_up=%b, want 4 0", state, link_up);
      end
      pcs_block_lock = 1'b1;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         n_checks++;
         if (w_dut !== w_exp) begin n_fails++; $display("FAIL glitch_model k=%0d: got %h, want %h", k, w_dut, w_exp); end
         if (link_up) begin n = k; break; end
      end
      n_checks++;
      if (n != LOCK_ST) begin n_fails++; $display("FAIL glitch_relock_time: got %0d, want %0d", n, LOCK_ST); end
   endtask

   task automatic test_txf_in_linkup();
      int n;
      sfp_txf = 1'b1; cyc();
      n_checks++;
      if ({state, link_up, sfp_txd, fault} !== {3'd6, 1'b0, 1'b1, 1'b1}) begin
         n_fails++; $display("FAIL txf_enter: got state=%0d lu=%b txd=%b fault=%b, want 6 0 1 1", state, link_up, sfp_txd, fault);
      end
      repeat (4) cyc();
      sfp_txf = 1'b0;
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         cyc();
         n_checks++;
         if (w_dut !== w_exp) begin n_fails++; $display("FAIL txf_model k=%0d: got %h, want %h", k, w_dut, w_exp); end
         if (state == 3'd1) begin n = k; break; end
      end
      n_checks++;
      if (n != TXF_REC) begin n_fails++; $display("FAIL txf_recover_time: got %0d, want %0d", n, TXF_REC); end
      n_checks++;
      if (retry_cnt !== 8'd1) begin n_fails++; $display("FAIL txf_retry: got %0d, want 1", retry_cnt); end
      n = 0;
      for (int k = 1; k <= 60; k++) begin
         cyc();
         if (link_up) begin n = k; break; end
      end
      n_checks++;
      if (n != TXD_HOLD + GT_RST + 1 + LOCK_ST || retry_cnt !== 8'd0) begin
         n_fails++; $display("FAIL txf_relink: got %0d retry=%0d, want %0d 0", n, retry_cnt, TXD_HOLD + GT_RST + 1 + LOCK_ST);
      end
   endtask

   task automatic test_link_loss();
      int n;
      sfp_sgd = 1'b0; cyc();
      n_checks++;
      if ({state, link_up, retry_cnt} !== {3'd1, 1'b0, 8'd0}) begin
         n_fails++; $display("FAIL loss_enter: got state=%0d lu=%b retry=%0d, want 1 0 0", state, link_up, retry_cnt);
      end
      sfp_sgd = 1'b1;
      n = 0;
      for (int k = 1; k <= 60; k++) begin
         cyc();
         n_checks++;
         if (w_dut !== w_exp) begin n_fails++; $display("FAIL loss_model k=%0d: got %h, want %h", k, w_dut, w_exp); end
         if (link_up) begin n = k; break; end
      end
      n_checks++;
      if (n != TXD_HOLD + GT_RST + 1 + LOCK_ST) begin
         n_fails++; $display("FAIL loss_recover_time: got %0d, want %0d", n, TXD_HOLD + GT_RST + 1 + LOCK_ST);
      end
   endtask

   task automatic test_rate_and_reset();
      int n;
      enable = 1'b0; cyc();
      rate_sel = 1'b0; enable = 1'b1; cyc();
      n_checks++;
      if ({state, sfp_rs} !== {3'd1, 1'b0}) begin
         n_fails++; $display("FAIL rate_latch: got state=%0d rs=%b, want 1 0", state, sfp_rs);
      end
      for (int k = 1; k <= 60; k++) begin
         cyc();
         if (link_up) break;
      end
      rate_sel = 1'b1;
      repeat (5) cyc();
      n_checks++;
      if ({link_up, sfp_rs} !== {1'b1, 1'b0}) begin
         n_fails++; $display("FAIL rate_ignored: got lu=%b rs=%b, want 1 0", link_up, sfp_rs);
      end
      enable = 1'b0; cyc();
      pcs_block_lock = 1'b0; enable = 1'b1;
      n = 0;
      for (int k = 1; k <= 50; k++) begin
         cyc();
         if (state == 3'd4) begin n = k; break; end
      end
      RESET = 1'b1; cyc();
      n_checks++;
      if (n == 0 || w_dut !== 17'b000_1_1_1_1_0_0_00000000) begin
         n_fails++; $display("FAIL reset_in_wait_lock: got %h (reached=%0d), want %h", w_dut, n, 17'b000_1_1_1_1_0_0_00000000);
      end
      RESET = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         RESET          = ($urandom_range(0, 999) < 2);
         enable         = ($urandom_range(0, 999) < 995);
         sfp_txf        = ($urandom_range(0, 999) < 4) || (sfp_txf && ($urandom_range(0, 3) != 0));
         sfp_sgd        = ($urandom_range(0, 999) < 992);
         gt_reset_done  = ($urandom_range(0, 9) < 7);
         rate_sel       = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 99) < 6) pcs_block_lock = ~pcs_block_lock;
         cyc();
         n_checks++;
         if (w_dut !== w_exp) begin n_fails++; $display("FAIL random_model i=%0d: got %h, want %h", i, w_dut, w_exp); end
      end
   endtask

   initial begin
      RESET = 1'b1; enable = 1'b0; rate_sel = 1'b0; sfp_sgd = 1'b0; sfp_txf = 1'b0;
      gt_reset_done = 1'b0; pcs_block_lock = 1'b0;
      test_reset();
      test_clean_bringup();
      test_no_lock();
      test_lock_glitch();
      test_txf_in_linkup();
      test_link_loss();
      test_rate_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
